valid_ready_pipe: RTL and testbench
===================================

// Module: valid_ready_pipe
// PURPOSE
//   Parametrised pipeline register chain with a valid/ready handshake, flush and an occupancy count.
//   It generalises the single enable-flop into DEPTH stages with per-stage stall (bubble collapse).
//   Sits between ALU/datapath stages wherever a WIDTH-bit value must be delayed, stalled or squashed.
// PARAMETERS
//   WIDTH   16  data bits per stage
//   DEPTH   2   number of register stages, must be >= 1
//   CNT_W   derived localparam = $clog2(DEPTH+1); width of the occupancy count
// PORTS
//   clk        in   1      clock, all state updates on posedge
//   reset      in   1      synchronous, active-low reset
//   flush      in   1      synchronous squash of all held entries
//   in_valid   in   1      producer has data on in_data
//   in_ready   out  1      pipe accepts in_data this cycle
//   in_data    in   WIDTH  input payload
//   out_valid  out  1      last stage holds valid data
//   out_ready  in   1      consumer accepts out_data this cycle
//   out_data   out  WIDTH  payload of the last stage
//   occupancy  out  CNT_W  number of stages currently valid, range 0..DEPTH
// BEHAVIOUR
//   - Stages 0..DEPTH-1 each hold vld[i] and dat[i]. Stage 0 is fed from the input; stage DEPTH-1 drives the outputs.
//   - ready chain (combinational): rdy[DEPTH]=out_ready; rdy[i] = ~vld[i] | rdy[i+1]. in_ready = rdy[0] & ~flush.
//   - out_valid = vld[DEPTH-1] & ~flush; out_data = dat[DEPTH-1] (not gated).
//   - Transfer into stage i when rdy[i]=1. The source is in_valid/in_data for i=0, else vld[i-1]/dat[i-1].
//     On transfer: vld[i] <= source valid; dat[i] loads only if source valid, else it holds its old value.
//   - Bubbles collapse: a valid stage advances into an empty downstream stage even while out_ready=0.
//   - Handshake: a transfer occurs when valid & ready are high in the same cycle. The producer holds in_data
//     stable while in_valid & ~in_ready. out_data/out_valid are stable while out_valid & ~out_ready.
//   - Latency: DEPTH cycles from input acceptance to out_valid with no backpressure. Throughput is 1 per cycle.
//   - Full pipe with out_ready=1 accepts a new input in the same cycle (in_ready=1). The ready chain is combinational.
//   - Full pipe with out_ready=0: in_ready=0 and all state holds.
//   - Empty pipe: out_valid=0, occupancy=0, and out_data shows the last held value.
//   - flush (priority over handshake): next cycle all vld=0 and occupancy=0. dat[] is unchanged.
//     While flush=1, no transfer counts on either port.
//   - reset=0 (priority over flush): next edge all vld=0 and all dat=0.
//     Resulting outputs: out_valid=0, out_data=0, occupancy=0.
//     in_ready is combinational and reads 1 after reset (pipe empty).
//   - Reset asserted mid-stream discards all held entries. No partial state survives.
//   - occupancy is registered and equals the popcount of vld[] after each edge.
//     Simultaneous in-accept and out-accept leave occupancy unchanged.
//   - DEPTH=1 degenerates to a single enable-flop with a valid bit and in_ready = ~vld | out_ready.
// STRUCTURE
//   - No shared-package content needed. CNT_W is a local derived localparam.
//     If the ready-chain helper is reused, the $clog2 helper goes into the shared ALU package.
//   - One sub-module, pipe_stage: a 1+WIDTH-bit register with load enable, sync active-low reset and
//     valid-clear. Instantiate it DEPTH times in a generate loop; the ready chain stays in the top level.
// TESTING (WIDTH=16, DEPTH=3 unless stated)
//   1. Reset: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, out_data=16'h0000, occupancy=0, in_ready=1.
//   2. Streaming: out_ready=1, drive 16'h0001..16'h0008 on consecutive cycles -> 16'h0001 appears 3 cycles after
//      its acceptance, then one word per cycle in order; occupancy holds at 3.
//   3. Backpressure: out_ready=0, push 16'hA001..A003 -> in_ready=0 after the 3rd accept and occupancy=3.
//      Then push 16'hA004 (held) and raise out_ready -> outputs A001, A002, A003, A004 in order, no loss or duplication.
//   4. Bubble collapse: accept 16'hBEEF, idle 1 cycle, accept 16'hCAFE, out_ready=0 -> both are packed into
//      stages 2 and 1 with occupancy=2; in_ready stays 1 until a 3rd word arrives.
//   5. Flush: pipe full (C001..C003), assert flush with in_valid=1 and in_data=16'hDEAD -> in_ready=0 and out_valid=0
//      during flush; next cycle occupancy=0 and DEAD is never output.
//   6. Reset mid-stream with flush=1 simultaneously: occupancy=2, pulse reset=0 for 1 cycle -> occupancy=0 and out_data=0;
//      with DEPTH=1, streaming 16'h1234 emerges 1 cycle after acceptance.

Source files
------------

// File: rtl/valid_ready_pipe_pkg.sv
// Shared constants and helpers for the valid/ready register pipe.
package valid_ready_pipe_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 2;
    // Upper bound on DEPTH supported by the occupancy popcount.
    localparam int MAX_DEPTH = 32;

    function automatic int unsigned count_ones(input logic [MAX_DEPTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/valid_ready_pipe_stage.sv
// One pipe stage: valid bit plus payload with load enable and valid-clear.
module pipe_stage
    import valid_ready_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             src_vld,
    input  logic [WIDTH-1:0] src_dat,
    output logic             vld,
    output logic [WIDTH-1:0] dat
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld <= 1'b0;
            dat <= '0;
        end else begin
            if (clear)
                vld <= 1'b0;
            else if (load)
                vld <= src_vld;
            // Payload only moves with a real entry, so a bubble never overwrites it.
            if (load && src_vld && !clear)
                dat <= src_dat;
        end
    end

endmodule

// File: rtl/valid_ready_pipe.sv
// DEPTH-stage register pipe with a combinational ready chain, flush and occupancy count.
module valid_ready_pipe
    import valid_ready_pipe_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] occupancy
);

    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0]            src_vld;
    logic [DEPTH-1:0]            vld_next;
    logic [DEPTH-1:0][WIDTH-1:0] dat;
    logic [DEPTH-1:0][WIDTH-1:0] src_dat;
    logic [DEPTH:0]              rdy;

    // A stage can take new data if it is empty or its occupant moves on this cycle.
    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--)
            rdy[i] = ~vld[i] | rdy[i+1];
    end

    always_comb begin
        src_vld    = '0;
        src_dat    = '0;
        src_vld[0] = in_valid;
        src_dat[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            src_vld[i] = vld[i-1];
            src_dat[i] = dat[i-1];
        end
    end

    always_comb begin
        vld_next = '0;
        for (int i = 0; i < DEPTH; i++)
            vld_next[i] = flush ? 1'b0 : (rdy[i] ? src_vld[i] : vld[i]);
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .reset   (reset),
            .clear   (flush),
            .load    (rdy[i]),
            .src_vld (src_vld[i]),
            .src_dat (src_dat[i]),
            .vld     (vld[i]),
            .dat     (dat[i])
        );
    end

    // Registered alongside the stages so it always matches the valid bits after the edge.
    always_ff @(posedge clk) begin
        if (!reset)
            occupancy <= '0;
        else
            occupancy <= CNT_W'(count_ones(MAX_DEPTH'(vld_next)));
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = vld[DEPTH-1] & ~flush;
    assign out_data  = dat[DEPTH-1];

endmodule

// File: tb/tb_valid_ready_pipe.sv
// Bench for valid_ready_pipe: vector table, directed corner sequences and a queue-based random model.
module tb_valid_ready_pipe;

    localparam int W = 16;
    localparam int D = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, flush, in_valid, out_ready, in_ready, out_valid;
    logic [W-1:0] in_data, out_data;
    logic [1:0]   occupancy;

    logic         reset1 = 1'b0, flush1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0;
    logic [W-1:0] in_data1 = '0;
    logic         in_ready1, out_valid1;
    logic [W-1:0] out_data1;
    logic [0:0]   occupancy1;

    valid_ready_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    valid_ready_pipe #(.WIDTH(W), .DEPTH(1)) dut1 (
        .clk(clk), .reset(reset1), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .occupancy(occupancy1)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: in-flight words, oldest first, each tagged with its stage index.
    logic [W-1:0] mq_dat[$];
    int           mq_pos[$];
    bit           mv[$];
    logic [W-1:0] m_last;
    logic [W-1:0] got_q[$];
    bit           last_acc;

    task automatic m_eval(output bit ir, output bit ov);
        mv.delete();
        for (int k = 0; k < mq_pos.size(); k++) begin
            bit m;
            if (k == 0) m = (mq_pos[0] == D - 1) ? bit'(out_ready) : 1'b1;
            else        m = (mq_pos[k] + 1 < mq_pos[k-1]) || mv[k-1];
            mv.push_back(m);
        end
        ir = !flush && (mq_pos.size() == 0 || mq_pos[mq_pos.size()-1] > 0 || mv[mv.size()-1]);
        ov = !flush && mq_pos.size() > 0 && mq_pos[0] == D - 1;
    endtask

    task automatic m_update();
        bit ir, ov, drop;
        if (!reset) begin
            mq_dat.delete(); mq_pos.delete(); m_last = '0;
            return;
        end
        m_eval(ir, ov);
        if (flush) begin
            mq_dat.delete(); mq_pos.delete();
            return;
        end
        drop = 1'b0;
        for (int k = 0; k < mq_pos.size(); k++) begin
            if (mv[k]) begin
                if (mq_pos[k] == D - 1) drop = 1'b1;
                else begin
                    mq_pos[k] = mq_pos[k] + 1;
                    if (mq_pos[k] == D - 1) m_last = mq_dat[k];
                end
            end
        end
        if (drop) begin
            void'(mq_dat.pop_front());
            void'(mq_pos.pop_front());
        end
        if (in_valid && ir) begin
            mq_dat.push_back(in_data);
            mq_pos.push_back(0);
        end
    endtask

    task automatic cyc(input logic r, input logic f, input logic iv, input logic [W-1:0] d,
                       input logic ordy);
        bit ir, ov;
        reset = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        #1;
        m_eval(ir, ov);
        chk("in_ready", in_ready, ir);
        chk("out_valid", out_valid, ov);
        chk("out_data", out_data, m_last);
        chk("occupancy", occupancy, mq_pos.size());
        last_acc = iv && ir && r;
        if (out_valid && out_ready) got_q.push_back(out_data);
        @(posedge clk);
        m_update();
        @(negedge clk);
    endtask

    task automatic idle_peek(input logic ordy);
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = ordy;
        #1;
    endtask

    typedef struct {
        logic         r, f, iv;
        logic [W-1:0] d;
        logic         ordy, c, ir, ov;
        logic [W-1:0] od;
        int           occ;
    } vec_t;

    function automatic vec_t mk(logic r, logic f, logic iv, logic [W-1:0] d, logic ordy,
                                logic c, logic ir, logic ov, logic [W-1:0] od, int occ);
        vec_t v;
        v.r = r; v.f = f; v.iv = iv; v.d = d; v.ordy = ordy;
        v.c = c; v.ir = ir; v.ov = ov; v.od = od; v.occ = occ;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin : main
        logic [W-1:0] exp3[4];
        logic [W-1:0] rd;
        bit           pend;

        // Reset with in_valid high, then streaming 1..8 with out_ready=1.
        tbl.push_back(mk(0, 0, 1, 16'h5555, 0, 0, 0, 0, 16'h0, 0));
        tbl.push_back(mk(0, 0, 1, 16'h5555, 0, 1, 1, 0, 16'h0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0,    1, 1, 1, 0, 16'h0, 0));
        for (int t = 0; t < 8; t++)
            tbl.push_back(mk(1, 0, 1, W'(t + 1), 1, 1, 1, t >= 3,
                             (t >= 3) ? W'(t - 2) : W'(0), (t < 3) ? t : 3));
        tbl.push_back(mk(1, 0, 0, 16'h0, 1, 1, 1, 1, 16'h6, 3));
        tbl.push_back(mk(1, 0, 0, 16'h0, 1, 1, 1, 1, 16'h7, 2));
        tbl.push_back(mk(1, 0, 0, 16'h0, 1, 1, 1, 1, 16'h8, 1));
        tbl.push_back(mk(1, 0, 0, 16'h0, 1, 1, 1, 0, 16'h8, 0));

        foreach (tbl[i]) begin
            reset = tbl[i].r; flush = tbl[i].f; in_valid = tbl[i].iv;
            in_data = tbl[i].d; out_ready = tbl[i].ordy;
            #1;
            if (tbl[i].c) begin
                chk("tbl_in_ready", in_ready, tbl[i].ir);
                chk("tbl_out_valid", out_valid, tbl[i].ov);
                chk("tbl_out_data", out_data, tbl[i].od);
                chk("tbl_occupancy", occupancy, tbl[i].occ);
            end
            @(posedge clk);
            m_update();
            @(negedge clk);
        end

        // Backpressure: fill, hold A004 while full, then drain in order.
        cyc(1, 0, 1, 16'hA001, 0);
        cyc(1, 0, 1, 16'hA002, 0);
        cyc(1, 0, 1, 16'hA003, 0);
        in_valid = 1'b1; in_data = 16'hA004;
        #1;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_occupancy", occupancy, 3);
        cyc(1, 0, 1, 16'hA004, 0);
        got_q.delete();
        cyc(1, 0, 1, 16'hA004, 1);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 16'h0, 1);
        exp3 = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
        chk("bp_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) chk("bp_order", got_q[i], exp3[i]);

        // Bubble collapse under out_ready=0.
        cyc(1, 0, 1, 16'hBEEF, 0);
        cyc(1, 0, 0, 16'h0, 0);
        cyc(1, 0, 1, 16'hCAFE, 0);
        cyc(1, 0, 0, 16'h0, 0);
        cyc(1, 0, 0, 16'h0, 0);
        idle_peek(0);
        chk("bub_occupancy", occupancy, 2);
        chk("bub_in_ready", in_ready, 1);
        chk("bub_out_data", out_data, 16'hBEEF);
        cyc(1, 0, 1, 16'h1111, 0);
        idle_peek(0);
        chk("bub_full_in_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 16'h0, 1);

        // Flush a full pipe while DEAD is offered.
        cyc(1, 0, 1, 16'hC001, 0);
        cyc(1, 0, 1, 16'hC002, 0);
        cyc(1, 0, 1, 16'hC003, 0);
        reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_data = 16'hDEAD; out_ready = 1'b1;
        #1;
        chk("fl_in_ready", in_ready, 0);
        chk("fl_out_valid", out_valid, 0);
        cyc(1, 1, 1, 16'hDEAD, 1);
        idle_peek(1);
        chk("fl_occupancy", occupancy, 0);
        got_q.delete();
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 16'h0, 1);
        chk("fl_nothing_out", got_q.size(), 0);

        // Reset together with flush while two words are held.
        cyc(1, 0, 1, 16'h6001, 0);
        cyc(1, 0, 1, 16'h6002, 0);
        idle_peek(0);
        chk("rs_occ_before", occupancy, 2);
        cyc(0, 1, 1, 16'h6003, 1);
        idle_peek(0);
        chk("rs_occupancy", occupancy, 0);
        chk("rs_out_data", out_data, 16'h0);
        chk("rs_in_ready", in_ready, 1);

        // Random traffic against the model; producer holds data while stalled.
        pend = 1'b0;
        rd   = '0;
        for (int n = 0; n < 400; n++) begin
            logic r, f, iv, o;
            r = ($urandom_range(0, 49) != 0);
            f = ($urandom_range(0, 19) == 0);
            o = ($urandom_range(0, 2) != 0);
            if (pend) iv = 1'b1;
            else begin
                iv = 1'($urandom_range(0, 1));
                rd = W'($urandom);
            end
            cyc(r, f, iv, rd, o);
            pend = iv && !last_acc && r;
        end

        // DEPTH=1: single enable-flop behaviour.
        reset1 = 1'b1; in_valid1 = 1'b1; in_data1 = 16'h1234; out_ready1 = 1'b1;
        #1;
        chk("d1_in_ready_empty", in_ready1, 1);
        chk("d1_out_valid_empty", out_valid1, 0);
        chk("d1_occ_empty", occupancy1, 0);
        @(posedge clk); @(negedge clk);
        in_valid1 = 1'b0;
        #1;
        chk("d1_out_valid", out_valid1, 1);
        chk("d1_out_data", out_data1, 16'h1234);
        chk("d1_occ", occupancy1, 1);
        in_valid1 = 1'b1; in_data1 = 16'h5678; out_ready1 = 1'b0;
        #1;
        chk("d1_full_stall", in_ready1, 0);
        @(posedge clk); @(negedge clk);
        #1;
        chk("d1_hold_data", out_data1, 16'h1234);
        out_ready1 = 1'b1;
        #1;
        chk("d1_full_pass", in_ready1, 1);
        @(posedge clk); @(negedge clk);
        in_valid1 = 1'b0;
        #1;
        chk("d1_next_data", out_data1, 16'h5678);
        chk("d1_next_occ", occupancy1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
